// File: rtl/dct_input_framer_if.sv
// Sample-stream and block-operand bundle between an upstream EEG source and the DCT input framer.
interface dct_input_framer_if #(
  parameter int unsigned SAMPLE_W = 8
);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;
  logic signed [SAMPLE_W-1:0] input0;
  logic signed [SAMPLE_W-1:0] input1;
  logic signed [SAMPLE_W-1:0] input2;
  logic signed [SAMPLE_W-1:0] input3;
  logic signed [SAMPLE_W-1:0] input4;
  logic signed [SAMPLE_W-1:0] input5;
  logic signed [SAMPLE_W-1:0] input6;
  logic signed [SAMPLE_W-1:0] input7;
  logic                       en;
  logic                       cs;
  logic                       block_done;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready,
    input  input0, input1, input2, input3, input4, input5, input6, input7,
    input  en, cs, block_done
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready,
    output input0, input1, input2, input3, input4, input5, input6, input7,
    output en, cs, block_done
  );
endinterface

// File: rtl/dct_input_framer.sv
// Ping-pong framer: packs serial samples into 8-sample banks and presents each bank
// as stable parallel operands for a fixed DCT enable window.
module dct_input_framer #(
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned DCT_CYCLES = 12,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dct_input_framer_if.slave bus
);

  localparam int unsigned NPTS = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 full_q, full_d;
  logic [2:0]                 wr_idx_q, wr_idx_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic signed [SAMPLE_W-1:0] bank_q [2][NPTS];
  logic signed [SAMPLE_W-1:0] ops_q [NPTS];
  logic signed [SAMPLE_W-1:0] ops_d [NPTS];
  logic                       ready_q, en_q, done_q;
  logic                       wr_fire;

  assign wr_fire = bus.sample_valid && ready_q;

  // Write-side bookkeeping and read FSM next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    ops_d     = ops_q;

    if (wr_fire) begin
      wr_idx_d = wr_idx_q + 3'd1;
      if (wr_idx_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          ops_d   = bank_q[rd_bank_q];
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DCT_CYCLES - 1)) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        // Flags are sampled registered: a bank completing this very edge waits for IDLE
        if (full_q[~rd_bank_q]) begin
          ops_d   = bank_q[~rd_bank_q];
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      full_q    <= '0;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      ready_q   <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NPTS; i++) ops_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ready_q   <= ~full_d[wr_bank_d];
      en_q      <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_RELEASE);
      ops_q     <= ops_d;
    end
  end

  // Sample storage needs no reset: contents are only read once a bank is marked full
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_bank_q][wr_idx_q] <= bus.sample_in;
  end

  assign bus.sample_ready = ready_q;
  assign bus.en           = en_q;
  assign bus.cs           = en_q;
  assign bus.block_done   = done_q;
  assign bus.input0       = ops_q[0];
  assign bus.input1       = ops_q[1];
  assign bus.input2       = ops_q[2];
  assign bus.input3       = ops_q[3];
  assign bus.input4       = ops_q[4];
  assign bus.input5       = ops_q[5];
  assign bus.input6       = ops_q[6];
  assign bus.input7       = ops_q[7];

endmodule

// File: tb/tb_dct_input_framer.sv
// Self-checking bench for dct_input_framer against a block/window timeline model.
module tb_dct_input_framer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dct_input_framer_if #(.SAMPLE_W(W)) ifa ();
  dct_input_framer_if #(.SAMPLE_W(W)) ifb ();

  dct_input_framer #(.SAMPLE_W(W), .DCT_CYCLES(12), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  dct_input_framer #(.SAMPLE_W(W), .DCT_CYCLES(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  bit   sel;
  int   dcyc;
  int   n_cmp, n_bad;
  int   cyc;
  logic o_en, o_cs, o_done, o_ready;
  logic [8*W-1:0] o_ops;

  always_comb begin
    if (sel) begin
      o_en = ifb.en; o_cs = ifb.cs; o_done = ifb.block_done; o_ready = ifb.sample_ready;
      o_ops = {ifb.input7, ifb.input6, ifb.input5, ifb.input4,
               ifb.input3, ifb.input2, ifb.input1, ifb.input0};
    end else begin
      o_en = ifa.en; o_cs = ifa.cs; o_done = ifa.block_done; o_ready = ifa.sample_ready;
      o_ops = {ifa.input7, ifa.input6, ifa.input5, ifa.input4,
               ifa.input3, ifa.input2, ifa.input1, ifa.input0};
    end
  end

  // Model: accepted samples, edge at which each block completed, first en cycle of each window
  logic [W-1:0] smp[$];
  int blk_t[$];
  int win_s[$];

  function automatic bit m_en(int c);
    for (int k = 0; k < win_s.size(); k++)
      if (c >= win_s[k] && c < win_s[k] + dcyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_done(int c);
    for (int k = 0; k < win_s.size(); k++)
      if (c == win_s[k] + dcyc) return 1'b1;
    return 1'b0;
  endfunction

  // Ready while fewer than two completed blocks are still unreleased
  function automatic bit m_ready(int c);
    int p;
    if (c < 1) return 1'b0;
    p = 0;
    for (int k = 0; k < blk_t.size(); k++) if (blk_t[k] <= c) p++;
    for (int k = 0; k < win_s.size(); k++) if (win_s[k] + dcyc + 1 <= c) p--;
    return p < 2;
  endfunction

  function automatic logic [3:0] m_ctl(int c);
    return {m_en(c), m_en(c), m_done(c), m_ready(c)};
  endfunction

  function automatic logic [8*W-1:0] m_ops(int c);
    logic [8*W-1:0] r;
    r = '0;
    for (int k = 0; k < win_s.size(); k++)
      if (win_s[k] <= c)
        for (int i = 0; i < 8; i++) r[i*W +: W] = smp[8*k+i];
    return r;
  endfunction

  // Drive one cycle from a negedge, advance past the posedge, update the model
  task automatic tick(input bit v, input logic [W-1:0] d, output bit acc);
    int s;
    acc = v && (o_ready === 1'b1);
    ifa.sample_in = d; ifb.sample_in = d;
    ifa.sample_valid = v && !sel;
    ifb.sample_valid = v && sel;
    @(posedge clk);
    cyc++;
    if (acc) begin
      smp.push_back(d);
      if (smp.size() % 8 == 0) begin
        s = cyc + 1;
        if (win_s.size() > 0 && win_s[$] + dcyc + 1 > s) s = win_s[$] + dcyc + 1;
        blk_t.push_back(cyc);
        win_s.push_back(s);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifa.sample_valid = 1'b0; ifb.sample_valid = 1'b0;
    ifa.sample_in = '0; ifb.sample_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    smp.delete(); blk_t.delete(); win_s.delete();
  endtask

  task automatic test_reset();
    bit acc;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_en, o_cs, o_done, o_ready} !== 4'b0000 || o_ops !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got ctl=%b ops=%h exp ctl=0000 ops=0", {o_en, o_cs, o_done, o_ready}, o_ops);
    end
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick(1'b0, '0, acc);
      n_cmp++;
      if ({o_en, o_cs, o_done, o_ready} !== m_ctl(cyc)) begin
        n_bad++;
        $display("FAIL reset_ctl cyc=%0d got=%b exp=%b", cyc, {o_en, o_cs, o_done, o_ready}, m_ctl(cyc));
      end
    end
  endtask

  task automatic test_basic();
    bit acc; int sent, n_en, n_done;
    do_reset();
    sent = 0; n_en = 0; n_done = 0;
    for (int c = 0; c < 26; c++) begin
      tick(sent < 8, W'(sent + 1), acc);
      if (acc) sent++;
      if (o_en === 1'b1) n_en++;
      if (o_done === 1'b1) n_done++;
      n_cmp++;
      if ({o_en, o_cs, o_done, o_ready} !== m_ctl(cyc)) begin
        n_bad++;
        $display("FAIL basic_ctl cyc=%0d got=%b exp=%b", cyc, {o_en, o_cs, o_done, o_ready}, m_ctl(cyc));
      end
      n_cmp++;
      if (o_ops !== m_ops(cyc)) begin
        n_bad++;
        $display("FAIL basic_ops cyc=%0d got=%h exp=%h", cyc, o_ops, m_ops(cyc));
      end
    end
    n_cmp++;
    if (n_en != 12 || n_done != 1) begin
      n_bad++;
      $display("FAIL basic_counts got en=%0d done=%0d exp en=12 done=1", n_en, n_done);
    end
  endtask

  task automatic test_stream16();
    bit acc, seen_hi, gap_done; int sent, gap;
    logic [W-1:0] d;
    do_reset();
    sent = 0; seen_hi = 0; gap_done = 0; gap = 0;
    for (int c = 0; c < 50; c++) begin
      d = (sent < 16) ? W'(-128 + sent) : W'(sent - 16);
      tick(sent < 24, d, acc);
      if (acc) sent++;
      if (seen_hi && o_en === 1'b0 && !gap_done) gap++;
      if (seen_hi && o_en === 1'b1 && gap > 0) gap_done = 1;
      if (o_en === 1'b1) seen_hi = 1;
      n_cmp++;
      if ({o_en, o_cs, o_done, o_ready} !== m_ctl(cyc)) begin
        n_bad++;
        $display("FAIL stream_ctl cyc=%0d got=%b exp=%b", cyc, {o_en, o_cs, o_done, o_ready}, m_ctl(cyc));
      end
      n_cmp++;
      if (o_ops !== m_ops(cyc)) begin
        n_bad++;
        $display("FAIL stream_ops cyc=%0d got=%h exp=%h", cyc, o_ops, m_ops(cyc));
      end
    end
    n_cmp++;
    if (gap != 1) begin
      n_bad++;
      $display("FAIL stream_gap got=%0d exp=1", gap);
    end
  endtask

  task automatic test_backpressure();
    bit acc, saw_low; int sent, fd, rr;
    do_reset();
    sent = 0; saw_low = 0; fd = -1; rr = -1;
    for (int c = 0; c < 50; c++) begin
      tick(sent < 24, W'($urandom), acc);
      if (acc) sent++;
      if (o_done === 1'b1 && fd < 0) fd = cyc;
      if (saw_low && rr < 0 && o_ready === 1'b1) rr = cyc;
      if (cyc > 0 && o_ready === 1'b0) saw_low = 1;
      n_cmp++;
      if ({o_en, o_cs, o_done, o_ready} !== m_ctl(cyc)) begin
        n_bad++;
        $display("FAIL bp_ctl cyc=%0d got=%b exp=%b", cyc, {o_en, o_cs, o_done, o_ready}, m_ctl(cyc));
      end
      n_cmp++;
      if (o_ops !== m_ops(cyc)) begin
        n_bad++;
        $display("FAIL bp_ops cyc=%0d got=%h exp=%h", cyc, o_ops, m_ops(cyc));
      end
    end
    n_cmp++;
    if (!saw_low || rr != fd + 1 || sent != 24) begin
      n_bad++;
      $display("FAIL bp_ready_rise got low=%0d rise=%0d done=%0d sent=%0d exp rise=done+1 sent=24", saw_low, rr, fd, sent);
    end
  endtask

  task automatic test_gaps();
    bit acc, v; int sent, t8, fe;
    logic [W-1:0] pat [4];
    pat[0] = 8'h7F; pat[1] = 8'h80; pat[2] = 8'h01; pat[3] = 8'hFF;
    do_reset();
    sent = 0; t8 = -1; fe = -1;
    for (int c = 0; c < 90; c++) begin
      v = (sent < 16) && ($urandom_range(1, 0) == 1);
      tick(v, pat[sent % 4] ^ W'(sent / 4), acc);
      if (acc) sent++;
      if (acc && sent == 8) t8 = cyc;
      if (o_en === 1'b1 && fe < 0) fe = cyc;
      n_cmp++;
      if ({o_en, o_cs, o_done, o_ready} !== m_ctl(cyc)) begin
        n_bad++;
        $display("FAIL gaps_ctl cyc=%0d got=%b exp=%b", cyc, {o_en, o_cs, o_done, o_ready}, m_ctl(cyc));
      end
      n_cmp++;
      if (o_ops !== m_ops(cyc)) begin
        n_bad++;
        $display("FAIL gaps_ops cyc=%0d got=%h exp=%h", cyc, o_ops, m_ops(cyc));
      end
    end
    n_cmp++;
    if (sent != 16 || fe != t8 + 1) begin
      n_bad++;
      $display("FAIL gaps_latency got sent=%0d en_start=%0d t8=%0d exp sent=16 en_start=t8+1", sent, fe, t8);
    end
  endtask

  task automatic test_mid_reset();
    bit acc; int sent;
    do_reset();
    sent = 0;
    for (int g = 0; g < 40 && sent < 11; g++) begin
      tick(1'b1, W'($urandom), acc);
      if (acc) sent++;
    end
    for (int g = 0; g < 40 && win_s.size() > 0 && cyc < win_s[0] + 4; g++) tick(1'b0, '0, acc);
    n_cmp++;
    if (win_s.size() == 0 || cyc != win_s[0] + 4 || o_en !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_setup got cyc=%0d en=%b exp en=1 at window cycle 5", cyc, o_en);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_en, o_cs, o_done, o_ready} !== 4'b0000 || o_ops !== '0) begin
      n_bad++;
      $display("FAIL midrst_clear got ctl=%b ops=%h exp ctl=0000 ops=0", {o_en, o_cs, o_done, o_ready}, o_ops);
    end
    @(negedge clk);
    do_reset();
    sent = 0;
    for (int c = 0; c < 26; c++) begin
      tick(sent < 8, W'($urandom), acc);
      if (acc) sent++;
      n_cmp++;
      if ({o_en, o_cs, o_done, o_ready} !== m_ctl(cyc)) begin
        n_bad++;
        $display("FAIL midrst_ctl cyc=%0d got=%b exp=%b", cyc, {o_en, o_cs, o_done, o_ready}, m_ctl(cyc));
      end
      n_cmp++;
      if (o_ops !== m_ops(cyc)) begin
        n_bad++;
        $display("FAIL midrst_ops cyc=%0d got=%h exp=%h", cyc, o_ops, m_ops(cyc));
      end
    end
  endtask

  task automatic test_short_window();
    bit acc; int sent, n_en, n_done;
    sel = 1'b1; dcyc = 2;
    do_reset();
    sent = 0; n_en = 0; n_done = 0;
    for (int c = 0; c < 24; c++) begin
      tick(sent < 16, W'($urandom), acc);
      if (acc) sent++;
      if (o_en === 1'b1) n_en++;
      if (o_done === 1'b1) n_done++;
      n_cmp++;
      if ({o_en, o_cs, o_done, o_ready} !== m_ctl(cyc)) begin
        n_bad++;
        $display("FAIL short_ctl cyc=%0d got=%b exp=%b", cyc, {o_en, o_cs, o_done, o_ready}, m_ctl(cyc));
      end
      n_cmp++;
      if (o_ops !== m_ops(cyc)) begin
        n_bad++;
        $display("FAIL short_ops cyc=%0d got=%h exp=%h", cyc, o_ops, m_ops(cyc));
      end
    end
    n_cmp++;
    if (n_en != 4 || n_done != 2) begin
      n_bad++;
      $display("FAIL short_counts got en=%0d done=%0d exp en=4 done=2", n_en, n_done);
    end
    sel = 1'b0; dcyc = 12;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    sel = 1'b0; dcyc = 12;
    rst_n = 1'b0;
    ifa.sample_valid = 1'b0; ifb.sample_valid = 1'b0;
    ifa.sample_in = '0; ifb.sample_in = '0;
    test_reset();
    test_basic();
    test_stream16();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_short_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
